// File: rtl/la_vmux_pkg.sv
// Shared constants, buffer-state encoding and helpers for the la_vmux pipelined mux family.
package la_vmux_pkg;

    localparam string LA_VMUX_ONEHOT   = "ONEHOT";
    localparam string LA_VMUX_PRIORITY = "PRIORITY";

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_FULL  = 2'b11
    } buf_state_e;

    // True when two or more bits are set; a running "seen one" chain, no adder.
    function automatic logic popcount_ge2(input logic [63:0] v);
        logic seen;
        logic ge2;
        seen = 1'b0;
        ge2  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ge2  = ge2 | (seen & v[i]);
            seen = seen | v[i];
        end
        return ge2;
    endfunction

endpackage

// File: rtl/la_vmux_skid.sv
// Generic 2-entry valid/ready register slice (main + skid) with full throughput.
module la_vmux_skid
    import la_vmux_pkg::*;
#(
    parameter int    W    = 9,
    parameter string PROP = "DEFAULT"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         load_main;
    logic         load_skid;
    logic         move_skid;
    logic         accept;
    logic         emit;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= in_data;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = BUF_FULL;
                end else if (emit) begin
                    state_d   = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // Input is blocked here, so only the drain path matters.
                if (emit) begin
                    move_skid = 1'b1;
                    state_d   = BUF_ONE;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/la_vmux_pipe.sv
// Registered M-input select mux (one-hot AND-OR or lowest-index priority) with valid/ready.
// Optional select-error detection enabled by defining LA_VMUX_PIPE_ERRCHK_EN.
module la_vmux_pipe
    import la_vmux_pkg::*;
#(
    parameter int    N    = 8,
    parameter int    M    = 8,
    parameter string MODE = "ONEHOT",
    parameter string PROP = "DEFAULT"
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   sel,
    input  logic [M*N-1:0] in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out,
    output logic           err,
    output logic           err_sticky,
    input  logic           err_clr
);

    logic [N-1:0] mux_w;

    generate
        if (MODE == LA_VMUX_PRIORITY) begin : g_prio
            always_comb begin
                mux_w = '0;
                for (int i = M - 1; i >= 0; i--) begin
                    if (sel[i]) begin
                        mux_w = in[i*N +: N];
                    end
                end
            end
        end else begin : g_onehot
            always_comb begin
                mux_w = '0;
                for (int i = 0; i < M; i++) begin
                    mux_w = mux_w | ({N{sel[i]}} & in[i*N +: N]);
                end
            end
        end
    endgenerate

`ifdef LA_VMUX_PIPE_ERRCHK_EN
    logic         sel_err_w;
    logic [N:0]   slice_out_w;
    logic         err_sticky_q;

    generate
        if (MODE == LA_VMUX_PRIORITY) begin : g_err_prio
            assign sel_err_w = ~|sel;
        end else begin : g_err_onehot
            assign sel_err_w = (~|sel) | popcount_ge2(64'(sel));
        end
    endgenerate

    // The error flag rides in the top bit so it stays paired with its word.
    la_vmux_skid #(
        .W    (N + 1),
        .PROP (PROP)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({sel_err_w, mux_w}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (slice_out_w)
    );

    assign out = slice_out_w[N-1:0];
    assign err = out_valid & slice_out_w[N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_sticky_q <= 1'b0;
        end else if (in_valid && in_ready && sel_err_w) begin
            err_sticky_q <= 1'b1;
        end else if (err_clr) begin
            err_sticky_q <= 1'b0;
        end
    end

    assign err_sticky = err_sticky_q;
`else
    logic unused_err_clr;

    la_vmux_skid #(
        .W    (N),
        .PROP (PROP)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (mux_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out)
    );

    assign err            = 1'b0;
    assign err_sticky     = 1'b0;
    assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_la_vmux_pipe.sv
// Scoreboard bench for la_vmux_pipe: one ONEHOT and one PRIORITY instance, M=8, N=8.
module tb_la_vmux_pipe;

`ifdef LA_VMUX_PIPE_ERRCHK_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;

    logic        oh_in_valid, oh_in_ready, oh_out_valid, oh_out_ready;
    logic [7:0]  oh_sel, oh_out;
    logic [63:0] oh_in;
    logic        oh_err, oh_err_sticky, oh_err_clr;

    logic        pr_in_valid, pr_in_ready, pr_out_valid, pr_out_ready;
    logic [7:0]  pr_sel, pr_out;
    logic [63:0] pr_in;
    logic        pr_err, pr_err_sticky, pr_err_clr;

    logic [8:0]  q_oh[$];
    logic [8:0]  q_pr[$];
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    la_vmux_pipe #(.N(8), .M(8), .MODE("ONEHOT"), .PROP("DEFAULT")) u_oh (
        .clk(clk), .reset(reset), .in_valid(oh_in_valid), .in_ready(oh_in_ready),
        .sel(oh_sel), .in(oh_in), .out_valid(oh_out_valid), .out_ready(oh_out_ready),
        .out(oh_out), .err(oh_err), .err_sticky(oh_err_sticky), .err_clr(oh_err_clr)
    );

    la_vmux_pipe #(.N(8), .M(8), .MODE("PRIORITY"), .PROP("DEFAULT")) u_pr (
        .clk(clk), .reset(reset), .in_valid(pr_in_valid), .in_ready(pr_in_ready),
        .sel(pr_sel), .in(pr_in), .out_valid(pr_out_valid), .out_ready(pr_out_ready),
        .out(pr_out), .err(pr_err), .err_sticky(pr_err_sticky), .err_clr(pr_err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int idx, input logic [7:0] v);
        logic [63:0] r;
        r = '0;
        r[idx*8 +: 8] = v;
        return r;
    endfunction

    function automatic logic [8:0] mdl_oh(input logic [7:0] s, input logic [63:0] d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (s[i]) r = r | d[i*8 +: 8];
        return {ERR && ($countones(s) != 1), r};
    endfunction

    function automatic logic [8:0] mdl_pr(input logic [7:0] s, input logic [63:0] d);
        logic [7:0] r;
        bit         found;
        r = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (s[i] && !found) begin
                r = d[i*8 +: 8];
                found = 1'b1;
            end
        end
        return {ERR && (s == 8'h00), r};
    endfunction

    always @(negedge clk) begin
        if (!reset && oh_out_valid && oh_out_ready) begin
            if (q_oh.size() == 0) chk("oh_extra_word", 32'(oh_out), 32'hFFFF_FFFF);
            else begin
                logic [8:0] e;
                e = q_oh.pop_front();
                chk("oh_data", 32'(oh_out), 32'(e[7:0]));
                chk("oh_err", 32'(oh_err), 32'(e[8]));
            end
        end
        if (!reset && pr_out_valid && pr_out_ready) begin
            if (q_pr.size() == 0) chk("pr_extra_word", 32'(pr_out), 32'hFFFF_FFFF);
            else begin
                logic [8:0] e;
                e = q_pr.pop_front();
                chk("pr_data", 32'(pr_out), 32'(e[7:0]));
                chk("pr_err", 32'(pr_err), 32'(e[8]));
            end
        end
    end

    task automatic oh_send(input logic [7:0] s, input logic [63:0] d);
        bit done;
        done = 1'b0;
        oh_sel = s; oh_in = d; oh_in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (oh_in_ready) begin
                q_oh.push_back(mdl_oh(s, d));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("oh_send_timeout", 0, 1);
        oh_in_valid = 1'b0;
    endtask

    task automatic pr_send(input logic [7:0] s, input logic [63:0] d);
        bit done;
        done = 1'b0;
        pr_sel = s; pr_in = d; pr_in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (pr_in_ready) begin
                q_pr.push_back(mdl_pr(s, d));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("pr_send_timeout", 0, 1);
        pr_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 40; c++) begin
            if (q_oh.size() == 0 && q_pr.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_oh", q_oh.size(), 0);
        chk("drain_pr", q_pr.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        oh_in_valid = 0; oh_sel = 0; oh_in = 0; oh_out_ready = 0; oh_err_clr = 0;
        pr_in_valid = 0; pr_sel = 0; pr_in = 0; pr_out_ready = 0; pr_err_clr = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_out_valid", 32'(oh_out_valid), 0);
        chk("rst_out", 32'(oh_out), 0);
        chk("rst_in_ready", 32'(oh_in_ready), 1);
        chk("rst_err", 32'(oh_err), 0);
        chk("rst_sticky", 32'(oh_err_sticky), 0);
        chk("rst_pr_in_ready", 32'(pr_in_ready), 1);

        // 1: one-hot single select, one-cycle latency
        oh_out_ready = 1'b1;
        oh_send(8'h04, mk(2, 8'hA5));
        chk("t1_valid", 32'(oh_out_valid), 1);
        chk("t1_out", 32'(oh_out), 32'hA5);
        chk("t1_err", 32'(oh_err), 0);
        @(posedge clk); #1;

        // 2: multi-select OR with error, then clear
        oh_send(8'h05, mk(0, 8'h0F) | mk(2, 8'hF0));
        chk("t2_out", 32'(oh_out), 32'hFF);
        chk("t2_sticky", 32'(oh_err_sticky), 32'(ERR));
        oh_err_clr = 1'b1;
        @(posedge clk); #1;
        oh_err_clr = 1'b0;
        chk("t2_sticky_clr", 32'(oh_err_sticky), 0);
        chk("t2_err_gone", 32'(oh_err), 0);

        // 3: priority mode
        pr_out_ready = 1'b1;
        pr_send(8'h06, mk(1, 8'h11) | mk(2, 8'h22));
        chk("t3_out", 32'(pr_out), 32'h11);
        pr_send(8'h00, mk(1, 8'h11));
        chk("t3_zero_out", 32'(pr_out), 32'h00);
        chk("t3_zero_err", 32'(pr_err), 32'(ERR));
        chk("t3_sticky", 32'(pr_err_sticky), 32'(ERR));
        drain();

        // 4: backpressure, skid fill and ordered release
        oh_out_ready = 1'b0;
        oh_send(8'h01, mk(0, 8'h01));
        chk("t4_ready_one", 32'(oh_in_ready), 1);
        oh_send(8'h01, mk(0, 8'h02));
        chk("t4_ready_low", 32'(oh_in_ready), 0);
        chk("t4_out1", 32'(oh_out), 32'h01);
        fork
            oh_send(8'h01, mk(0, 8'h03));
            begin
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("t4_hold", 32'(oh_out), 32'h01);
                    chk("t4_hold_ready", 32'(oh_in_ready), 0);
                end
                oh_out_ready = 1'b1;
                @(posedge clk); #1;
                chk("t4_ready_back", 32'(oh_in_ready), 1);
                chk("t4_out2", 32'(oh_out), 32'h02);
            end
        join
        drain();

        // 5: reset while full, erroneous word stalled in main
        oh_out_ready = 1'b0;
        oh_send(8'h03, mk(0, 8'h3C) | mk(1, 8'h41));
        oh_send(8'h08, mk(3, 8'h77));
        @(posedge clk); #1;
        chk("t5_stall_err", 32'(oh_err), 32'(ERR));
        chk("t5_stall_out", 32'(oh_out), 32'h7D);
        chk("t5_sticky_pre", 32'(oh_err_sticky), 32'(ERR));
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(oh_out_valid), 0);
        chk("t5_rst_out", 32'(oh_out), 0);
        chk("t5_rst_ready", 32'(oh_in_ready), 1);
        chk("t5_rst_sticky", 32'(oh_err_sticky), 0);
        q_oh.delete();
        q_pr.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        oh_out_ready = 1'b1;
        pr_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("t5_no_stale", 32'(oh_out_valid), 0);

        // 6: clear and erroneous accept in the same cycle
        oh_err_clr = 1'b1;
        oh_send(8'h00, mk(0, 8'h99));
        chk("t6_set_wins", 32'(oh_err_sticky), 32'(ERR));
        oh_err_clr = 1'b0;
        @(posedge clk); #1;
        chk("t6_sticky_hold", 32'(oh_err_sticky), 32'(ERR));
        drain();

        // Random priority stream under random backpressure
        fork
            begin
                logic [7:0] s;
                for (int k = 0; k < 40; k++) begin
                    s = 8'($urandom_range(0, 255));
                    if (k % 5 == 0) s = 8'h00;
                    pr_send(s, {$urandom, $urandom});
                end
            end
            begin
                for (int c = 0; c < 150; c++) begin
                    @(posedge clk); #1;
                    pr_out_ready = ($urandom_range(0, 3) != 0);
                end
                pr_out_ready = 1'b1;
            end
        join
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
